// File: rtl/c432_lock_pkg.sv
// Shared constants and types for the c432 lock-key loader.
// KEY_CRC_EN selects whether a CRC field trails the key payload.
package c432_lock_pkg;

    localparam int XOR_BITS = 43;
    localparam int MUX_BITS = 4;
    localparam int CRC_W    = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    localparam int PAY_BITS = XOR_BITS + MUX_BITS;
`ifdef KEY_CRC_EN
    localparam int KEY_BITS = PAY_BITS + CRC_W;
`else
    localparam int KEY_BITS = PAY_BITS;
`endif
    localparam int CNT_W = $clog2(KEY_BITS);

    typedef logic [XOR_BITS-1:0] key_xor_t;
    typedef logic [MUX_BITS-1:0] key_mux_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    localparam cnt_t CNT_XOR  = cnt_t'(XOR_BITS);
    localparam cnt_t CNT_PAY  = cnt_t'(PAY_BITS);
    localparam cnt_t CNT_LAST = cnt_t'(KEY_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/c432_key_crc.sv
// Bit-serial MSB-first Galois CRC over the key payload, built only with KEY_CRC_EN.
// Latency: crc_out reflects every enabled bit one cycle after it is presented.
// Backpressure: none; the caller gates enable with its own handshake.
`ifdef KEY_CRC_EN
module c432_key_crc
    import c432_lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[CRC_W-1] ^ data_in;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule
`endif

// File: rtl/c432_key_loader.sv
// Serial-to-parallel c432 unlock-key loader with check and atomic commit (CRC field under KEY_CRC_EN).
// Latency: last bit accepted in cycle t -> committed key and key_valid at t+2.
// Backpressure: ser_ready high only while shifting; ser_valid low stalls the bit counter.
module c432_key_loader
    import c432_lock_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  logic     ser_valid,
    input  logic     ser_data,
    output logic     ser_ready,
    output key_xor_t key_xor,
    output key_mux_t key_mux,
    output logic     key_valid,
    output logic     busy,
    output logic     err
);

    loader_state_t state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    key_xor_t      shx_q, shx_d;
    key_mux_t      shm_q, shm_d;
    key_xor_t      kx_q, kx_d;
    key_mux_t      km_q, km_d;
    logic          kv_q, kv_d;
    logic          err_q, err_d;
    logic          pass;

`ifdef KEY_CRC_EN
    logic [CRC_W-1:0] rcrc_q, rcrc_d;
    logic [CRC_W-1:0] crc_calc;
    logic             crc_en;

    // Only payload bits feed the CRC; the received CRC field itself is excluded.
    assign crc_en = (state_q == SHIFT) && ser_valid && !start && (cnt_q < CNT_PAY);

    c432_key_crc u_crc (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  (crc_en),
        .data_in (ser_data),
        .crc_out (crc_calc)
    );

    assign pass = (crc_calc == rcrc_q);
`else
    assign pass = (shm_q != '0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shx_d   = shx_q;
        shm_d   = shm_q;
        kx_d    = kx_q;
        km_d    = km_q;
        kv_d    = kv_q;
        err_d   = err_q;
`ifdef KEY_CRC_EN
        rcrc_d  = rcrc_q;
`endif
        if (start) begin
            // Abort/restart: committed key stays applied until the next commit or fail.
            state_d = SHIFT;
            cnt_d   = '0;
            shx_d   = '0;
            shm_d   = '0;
            err_d   = 1'b0;
`ifdef KEY_CRC_EN
            rcrc_d  = '0;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (ser_valid) begin
                        // LSB-first arrival: shifting in at the top leaves bit 0 at index 0.
                        if (cnt_q < CNT_XOR) begin
                            shx_d = {ser_data, shx_q[XOR_BITS-1:1]};
                        end else if (cnt_q < CNT_PAY) begin
                            shm_d = {ser_data, shm_q[MUX_BITS-1:1]};
                        end
`ifdef KEY_CRC_EN
                        else begin
                            rcrc_d = {rcrc_q[CRC_W-2:0], ser_data};
                        end
`endif
                        if (cnt_q == CNT_LAST) begin
                            state_d = CHECK;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                end
                CHECK: begin
                    if (pass) begin
                        kx_d    = shx_q;
                        km_d    = shm_q;
                        kv_d    = 1'b1;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        kx_d    = '0;
                        km_d    = '0;
                        kv_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
                IDLE, DONE, ERROR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shx_q   <= '0;
            shm_q   <= '0;
            kx_q    <= '0;
            km_q    <= '0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef KEY_CRC_EN
            rcrc_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shx_q   <= shx_d;
            shm_q   <= shm_d;
            kx_q    <= kx_d;
            km_q    <= km_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
`ifdef KEY_CRC_EN
            rcrc_q  <= rcrc_d;
`endif
        end
    end

    assign ser_ready = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT) || (state_q == CHECK);
    assign key_xor   = kx_q;
    assign key_mux   = km_q;
    assign key_valid = kv_q;
    assign err       = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Bench for c432_key_loader in its default (no CRC) build.
module tb_c432_key_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ser_valid;
    logic        ser_data;
    logic        ser_ready;
    logic [42:0] key_xor;
    logic [3:0]  key_mux;
    logic        key_valid;
    logic        busy;
    logic        err;

    c432_key_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .key_xor   (key_xor),
        .key_mux   (key_mux),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [42:0] kx;
        logic [3:0]  km;
        logic        kv;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_busy;

    localparam logic [42:0] KA = 43'h2A5_5A5A_5A5A;
    localparam logic [42:0] KB = 43'h123_4567_89AB;
    localparam logic [42:0] KC = 43'h7FF_0000_FFFF;
    localparam logic [42:0] KD = 43'h555_AAAA_0F0F;
    localparam logic [42:0] KF = 43'h7AB_CDEF_0123;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: committed key must hold while busy; each busy->idle transition pops one expectation.
    initial begin
        exp_t e;
        prev_busy = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                chk("held_key", {key_xor, key_mux, key_valid}, {held.kx, held.km, held.kv});
            end
            if (prev_busy === 1'b1 && busy !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got busy fall expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("res_xor",   key_xor,   e.kx);
                    chk("res_mux",   key_mux,   e.km);
                    chk("res_valid", key_valid, e.kv);
                    chk("res_err",   err,       e.er);
                    held = e;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit stall);
        if (stall) begin
            ser_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        ser_valid = 1'b1;
        ser_data  = b;
        chk("ser_ready", ser_ready, 1);
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [46:0] w, input int nbits, input bit stall);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[i], stall);
        end
    endtask

    task automatic load_bits(input logic [42:0] kx, input logic [3:0] km, input bit stall, input bit good);
        exp_t e;
        e = good ? {kx, km, 1'b1, 1'b0} : {43'h0, 4'h0, 1'b0, 1'b1};
        exp_q.push_back(e);
        send_bits({km, kx}, 47, stall);
        chk("check_busy", busy, 1);
        chk("check_ready", ser_ready, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", key_valid, good);
        chk("lat_err", err, !good);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic full_load(input logic [42:0] kx, input logic [3:0] km, input bit stall, input bit good);
        do_start;
        load_bits(kx, km, stall, good);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_xor", key_xor, 0);
        chk("rst_mux", key_mux, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ser_ready, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_ready", ser_ready, 0);
        end
        ser_valid = 1'b0;

        full_load(KA, 4'b1001, 1'b0, 1'b1);
        full_load(KA, 4'b1001, 1'b1, 1'b1);

        // Abort after 20 bits, then a full reload.
        do_start;
        send_bits({4'b1111, KC}, 20, 1'b0);
        full_load(KB, 4'b0110, 1'b0, 1'b1);

        // start coincident with the last-bit handshake discards that bit.
        do_start;
        send_bits({4'b1111, KC}, 46, 1'b0);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ser_valid = 1'b0;
        chk("coinc_busy", busy, 1);
        load_bits(KD, 4'b0011, 1'b0, 1'b1);

        full_load(KF, 4'b0000, 1'b0, 1'b0);
        do_start;
        chk("start_clr_err", err, 0);
        send_bits({4'b0110, KB}, 10, 1'b0);
        full_load(KB, 4'b0110, 1'b0, 1'b1);

        // Reset while bit 30 of a reload is on the wire.
        do_start;
        send_bits({4'b1001, KA}, 30, 1'b0);
        exp_q.push_back('0);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ser_valid = 1'b0;
        chk("mrst_xor", key_xor, 0);
        chk("mrst_mux", key_mux, 0);
        chk("mrst_valid", key_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", ser_ready, 0);
        full_load(KA, 4'b1001, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
